// File: rtl/q_analog_prng_mc_pkg.sv
// Shared types and helpers for the multi-lane Q-analog PRNG.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package q_prng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Widest Mersenne exponent the helpers are sized for.
    localparam int MAX_E = 127;

    // Modulus 2^e - 1, right-aligned in a MAX_E-wide word.
    function automatic logic [MAX_E-1:0] mersenne_mod(input int e);
        return {MAX_E{1'b1}} >> (MAX_E - e);
    endfunction

    // Lane word: the low out_w bits of x when out_w <= e, otherwise x with its
    // own low bits replicated above it to fill out_w.
    function automatic logic [2*MAX_E-1:0] lane_map(input logic [MAX_E-1:0] x,
                                                    input int e,
                                                    input int out_w);
        logic [2*MAX_E-1:0] wide;
        logic [2*MAX_E-1:0] mask;
        wide = {{MAX_E{1'b0}}, x};
        mask = {(2*MAX_E){1'b1}} >> (2*MAX_E - out_w);
        return (wide | (wide << e)) & mask;
    endfunction

endpackage

// File: rtl/q_analog_prng_mc_if.sv
// Seed-write channel and output word stream of the multi-lane PRNG.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the stream; seed_ready gates seed writes.
interface q_analog_prng_mc_if #(
    parameter int E     = 61,
    parameter int LANES = 4,
    parameter int OUT_W = 64,
    parameter int LW    = 2
);
    logic                   seed_valid;
    logic [LW-1:0]          seed_lane;
    logic [E-1:0]           seed;
    logic                   seed_ready;
    logic                   seed_err;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;

    // Generator side.
    modport master (
        input  seed_valid, seed_lane, seed, out_ready,
        output seed_ready, seed_err, out_valid, out_data
    );

    // Host / sink side.
    modport slave (
        output seed_valid, seed_lane, seed, out_ready,
        input  seed_ready, seed_err, out_valid, out_data
    );
endinterface

// File: rtl/q_analog_prng_mc_mulmod.sv
// One Lehmer step: y = Q_VAL * x mod (2^E - 1), by Mersenne folding.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module mersenne_mulmod
    import q_prng_pkg::*;
#(
    parameter int          E     = 61,
    parameter int unsigned Q_VAL = 1025
) (
    input  logic [E-1:0] x,
    output logic [E-1:0] y
);
    localparam int             Q_W   = $clog2(Q_VAL + 1);
    localparam int             P_W   = E + Q_W;
    localparam logic [E-1:0]   M     = E'(mersenne_mod(E));
    localparam logic [P_W-1:0] Q_EXT = P_W'(Q_VAL);

    logic [P_W-1:0] p;
    logic [E:0]     s;
    logic [E-1:0]   r;

    // Fold the high part back in twice (2^E == 1 mod M), then map M to 0.
    always_comb begin
        p = Q_EXT * {{Q_W{1'b0}}, x};
        s = {1'b0, p[E-1:0]} + {{(E+1-Q_W){1'b0}}, p[P_W-1:E]};
        r = s[E-1:0] + {{(E-1){1'b0}}, s[E]};
        y = (r == M) ? '0 : r;
    end
endmodule

// File: rtl/q_analog_prng_mc.sv
// Multi-lane lockstep Lehmer PRNG with seed bank, run/stop FSM and output register.
// Latency: word valid one cycle after start; one new word per handshake cycle.
// Backpressure: out_ready low freezes out_data and all lane states.
module q_analog_prng_mc
    import q_prng_pkg::*;
#(
    parameter int          E     = 61,
    parameter int unsigned Q_VAL = 1025,
    parameter int          LANES = 4,
    parameter int          OUT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    q_analog_prng_mc_if.master   bus,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    output logic [31:0]          sample_cnt
);
    localparam int           LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [E-1:0] M  = E'(mersenne_mod(E));

    state_t                 state;
    state_t                 state_nxt;
    logic [E-1:0]           x      [LANES];
    logic [E-1:0]           x_in   [LANES];
    logic [E-1:0]           x_step [LANES];
    logic [LANES-1:0]       seeded;
    logic [LANES-1:0]       seeded_in;
    logic [LANES*OUT_W-1:0] out_map;
    logic [LANES*OUT_W-1:0] out_data_q;
    logic                   out_valid_q;
    logic                   out_valid_nxt;
    logic                   seed_err_q;
    logic                   seed_fire;
    logic                   seed_ok;
    logic                   hs;
    logic                   step;

    assign bus.seed_ready = (state == IDLE);
    assign bus.seed_err   = seed_err_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign busy           = (state != IDLE);

    assign seed_fire = bus.seed_valid && bus.seed_ready;
    assign seed_ok   = (bus.seed != '0) && (bus.seed != M) &&
                       ({1'b0, bus.seed_lane} < (LW+1)'(LANES));
    assign hs        = out_valid_q && bus.out_ready;

    // Per lane: merge an accepted seed ahead of the step so that a start in the
    // same cycle sees the new seed, then compute the next value and its word.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic sel;
        assign sel          = seed_fire && seed_ok && (bus.seed_lane == LW'(i));
        assign x_in[i]      = sel ? bus.seed : x[i];
        assign seeded_in[i] = sel | seeded[i];

        mersenne_mulmod #(.E(E), .Q_VAL(Q_VAL)) u_mulmod (
            .x (x_in[i]),
            .y (x_step[i])
        );

        assign out_map[i*OUT_W +: OUT_W] = OUT_W'(lane_map(MAX_E'(x_step[i]), E, OUT_W));
    end

    // Next-state and step decision; the handshake that ends a run never steps.
    always_comb begin
        state_nxt     = state;
        step          = 1'b0;
        out_valid_nxt = out_valid_q;
        case (state)
            IDLE: begin
                if (start && (&seeded_in)) begin
                    state_nxt     = RUN;
                    step          = 1'b1;
                    out_valid_nxt = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    if (hs) begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (hs) begin
                    step = 1'b1;
                end
            end
            DRAIN: begin
                if (hs) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Seed bank, lane states, output word and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seeded      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            seed_err_q  <= 1'b0;
            sample_cnt  <= '0;
            for (int i = 0; i < LANES; i++) begin
                x[i] <= '0;
            end
        end else begin
            seeded      <= seeded_in;
            seed_err_q  <= seed_fire && !seed_ok;
            out_valid_q <= out_valid_nxt;
            if (hs) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (step) begin
                out_data_q <= out_map;
            end
            for (int i = 0; i < LANES; i++) begin
                x[i] <= step ? x_step[i] : x_in[i];
            end
        end
    end
endmodule

// File: tb/tb_q_analog_prng_mc.sv
// Scoreboarded directed bench for the multi-lane PRNG.
// Latency: expects the first word one cycle after start.
// Backpressure: drives out_ready low/high and stop to exercise stall and drain.
module tb_q_analog_prng_mc;
    localparam logic [60:0] M = 61'h1FFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        busy;
    logic [31:0] sample_cnt;
    int          tests;
    int          fails;
    logic [255:0] exp_q [$];

    q_analog_prng_mc_if #(.E(61), .LANES(4), .OUT_W(64), .LW(2)) bus ();

    q_analog_prng_mc #(.E(61), .Q_VAL(1025), .LANES(4), .OUT_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed lane words: sel 0 = seed M-1, 1 = seed 1, 2 = seed 2.
    function automatic logic [63:0] lane_exp(input int sel, input int k);
        logic [63:0] v;
        v = '0;
        case (sel)
            0: case (k)
                1: v = 64'hDFFF_FFFF_FFFF_FBFE;
                2: v = 64'hDFFF_FFFF_FFEF_F7FE;
                3: v = 64'hDFFF_FFFF_BFCF_F3FE;
                4: v = 64'hDFFF_FEFE_FF9F_EFFE;
                5: v = 64'hDFFB_FAFD_7F5F_EBFE;
                default: v = '0;
            endcase
            1: case (k)
                1: v = 64'h2000_0000_0000_0401;
                2: v = 64'h2000_0000_0010_0801;
                3: v = 64'h2000_0000_4030_0C01;
                4: v = 64'h2000_0101_0060_1001;
                5: v = 64'h2004_0502_80A0_1401;
                default: v = '0;
            endcase
            default: case (k)
                1: v = 64'h4000_0000_0000_0802;
                2: v = 64'h4000_0000_0020_1002;
                3: v = 64'h4000_0000_8060_1802;
                4: v = 64'h4000_0202_00C0_2002;
                5: v = 64'h4008_0A05_0140_2802;
                default: v = '0;
            endcase
        endcase
        return v;
    endfunction

    // Lane 0 seeded M-1, lanes 1 and 2 seeded 1, lane 3 seeded 2.
    function automatic logic [255:0] wexp(input int k);
        return {lane_exp(2, k), lane_exp(1, k), lane_exp(1, k), lane_exp(0, k)};
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_write(input logic [1:0] lane, input logic [60:0] val);
        bus.seed_valid = 1'b1;
        bus.seed_lane  = lane;
        bus.seed       = val;
        tick();
        bus.seed_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"},  256'(bus.out_valid),  256'(0));
        check({tag, "_out_data"},   256'(bus.out_data),   256'(0));
        check({tag, "_seed_err"},   256'(bus.seed_err),   256'(0));
        check({tag, "_sample_cnt"}, 256'(sample_cnt),     256'(0));
        check({tag, "_busy"},       256'(busy),           256'(0));
        check({tag, "_seed_ready"}, 256'(bus.seed_ready), 256'(1));
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared.
    initial begin
        logic [255:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL word_unexpected: got %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed_lane = '0;
        bus.seed = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Seed three lanes; start must be ignored while lane 2 is unseeded.
        seed_write(2'd0, M - 61'd1);
        check("good_seed_no_err", 256'(bus.seed_err), 256'(0));
        seed_write(2'd1, 61'd1);
        seed_write(2'd3, 61'd2);
        start = 1'b1; tick(); start = 1'b0;
        check("start_unseeded_busy", 256'(busy), 256'(0));

        // Seed 0 is rejected with a one-cycle error pulse.
        seed_write(2'd2, 61'd0);
        check("seed0_err", 256'(bus.seed_err), 256'(1));
        start = 1'b1; tick(); start = 1'b0;
        check("seed0_err_pulse_end", 256'(bus.seed_err), 256'(0));
        check("seed0_busy", 256'(busy), 256'(0));

        // Seed M is rejected the same way.
        seed_write(2'd2, M);
        check("seedM_err", 256'(bus.seed_err), 256'(1));
        start = 1'b1; tick(); start = 1'b0;
        check("seedM_err_pulse_end", 256'(bus.seed_err), 256'(0));
        check("seedM_busy", 256'(busy), 256'(0));

        // Seed write and start together: seed applies first, run begins.
        for (int k = 1; k <= 5; k++) exp_q.push_back(wexp(k));
        bus.seed_valid = 1'b1; bus.seed_lane = 2'd2; bus.seed = 61'd1; start = 1'b1;
        tick();
        bus.seed_valid = 1'b0; start = 1'b0;
        check("run_busy", 256'(busy), 256'(1));
        check("run_valid", 256'(bus.out_valid), 256'(1));
        check("run_seed_ready", 256'(bus.seed_ready), 256'(0));

        // Two back-to-back handshakes, then 5 cycles of backpressure.
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        check("cnt_after_two", 256'(sample_cnt), 256'(2));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_data", bus.out_data, wexp(3));
            check("stall_cnt", 256'(sample_cnt), 256'(2));
        end

        // Release for one word, then stop without a handshake -> drain.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("drain_busy", 256'(busy), 256'(1));
        check("drain_valid", 256'(bus.out_valid), 256'(1));
        check("drain_data", bus.out_data, wexp(4));
        check("drain_cnt", 256'(sample_cnt), 256'(3));
        tick();
        check("drain_hold", bus.out_data, wexp(4));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("drain_done_busy", 256'(busy), 256'(0));
        check("drain_done_valid", 256'(bus.out_valid), 256'(0));
        check("drain_done_cnt", 256'(sample_cnt), 256'(4));

        // Resume continues the sequence; stop with handshake ends at once.
        start = 1'b1; tick(); start = 1'b0;
        check("resume_valid", 256'(bus.out_valid), 256'(1));
        check("resume_data", bus.out_data, wexp(5));
        bus.out_ready = 1'b1; stop = 1'b1;
        tick();
        bus.out_ready = 1'b0; stop = 1'b0;
        check("stop_hs_valid", 256'(bus.out_valid), 256'(0));
        check("stop_hs_busy", 256'(busy), 256'(0));
        check("stop_hs_cnt", 256'(sample_cnt), 256'(5));

        // Reset mid-run discards everything; start without seeds is ignored.
        start = 1'b1; tick(); start = 1'b0;
        check("prereset_busy", 256'(busy), 256'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_state("midrun_reset");
        start = 1'b1; tick(); start = 1'b0;
        check("post_reset_start_busy", 256'(busy), 256'(0));
        check("post_reset_start_valid", 256'(bus.out_valid), 256'(0));

        tick();
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/q_analog_prng_mc.md
# q_analog_prng_mc

Multi-lane successor to the single-stream Q-analog PRNG. Each of `LANES` lanes steps its own Lehmer-style sequence x(n+1) = `Q_VAL`·x(n) mod (2^`E` − 1) with a per-lane seed. All lanes advance in lockstep, one step per accepted output. Output is a registered valid/ready stream with full backpressure and run/stop control, so it can feed a DMA or file-dump sink directly instead of free-running on `en`.

## Interface
Parameters:
- `E`, 61, Mersenne exponent; modulus M = 2^E − 1; 2 ≤ E ≤ 127.
- `Q_VAL`, 1025, multiplier; 2 ≤ Q_VAL < M.
- `LANES`, 4, number of independent generators; ≥ 1.
- `OUT_W`, 64, bits emitted per lane; 1 ≤ OUT_W ≤ 2·E.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `seed_valid` in 1: seed write request.
- `seed_lane` in max(1,$clog2(LANES)): target lane.
- `seed` in E: seed value.
- `seed_ready` out 1: high only in IDLE.
- `seed_err` out 1: one-cycle pulse when a seed write is rejected.
- `start` in 1: begin or resume generation.
- `stop` in 1: end generation after the pending word.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: sink accepts the word.
- `out_data` out LANES·OUT_W: lane i occupies bits [i·OUT_W +: OUT_W].
- `busy` out 1: state ≠ IDLE.
- `sample_cnt` out 32: accepted-word count; wraps modulo 2^32.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **Seed writes** are accepted only when `seed_valid` and `seed_ready` are both high.
  - Seed 0 or M is rejected: `seed_err` = 1 on the next cycle, and the lane's seeded flag and state are unchanged.
  - `seed_lane` ≥ LANES is also rejected.
  - Otherwise x[lane] ← seed and seeded[lane] ← 1.
- **IDLE → RUN:** on `start` when all seeded flags are 1; `start` is ignored otherwise. On this transition every lane steps once and the result is loaded into the output register, so `out_valid` = 1.
- **In RUN:**
  - A handshake (`out_valid` & `out_ready`) steps every lane and reloads `out_data`; `out_valid` stays 1, giving one word per cycle.
  - Without a handshake, `out_data` and all x are frozen.
- **`stop` in RUN:**
  - With a handshake in the same cycle → IDLE, `out_valid` = 0 next cycle.
  - Without a handshake → DRAIN.
  - DRAIN holds the word until the handshake, then → IDLE.
  - Lanes are not stepped on the handshake that ends the run.
- **Resume:** lane state and seeded flags persist in IDLE. A later `start` continues the sequence without repeating a value.
- **Simultaneous `start` and `seed_valid` in IDLE:** the seed write is applied first, then the start rule is evaluated on the updated flags.
- **`sample_cnt`** increments on every handshake.
- **Mod-multiply:** product P = Q_VAL·x has width E + $clog2(Q_VAL+1).
  - s = P[E−1:0] + (P >> E).
  - r = s[E−1:0] + s[E].
  - Result is 0 if r == M, else r.
  - Nonzero seeds never reach 0.
- **Lane output mapping:**
  - If OUT_W ≤ E: x[OUT_W−1:0].
  - Else: {x[OUT_W−E−1:0], x}, i.e. the low bits are replicated on top.
- **Reset values:** x = 0, seeded = 0, state IDLE, `out_valid` 0, `out_data` 0, `seed_err` 0, `sample_cnt` 0, `busy` 0. `seed_ready` = 1 from the cycle after reset. Reset mid-run discards the pending word.

## Timing
- `start` sampled at edge t → `out_valid` = 1 after edge t, carrying Q·seed.
- Handshake at edge k → new `out_data` after edge k; zero-bubble throughput.
- `seed_err` asserts for exactly one cycle after the rejecting edge.
- Mod-multiply is one combinational stage per lane, registered in x. No multicycle paths.
- `out_data` is driven only from flops.

## Structure
- **Package `q_prng_pkg`:**
  - state enum (IDLE, RUN, DRAIN);
  - function `mersenne_mod(E)` returning M;
  - function for the lane output mapping.
- **Sub-module `mersenne_mulmod`** (params E, Q_VAL): one per lane, combinational x → Q·x mod M.
- **Top level:** FSM, seed bank, output register, counter.

## Test plan
- **Basic sequence** (E=61, Q=1025, LANES=4, OUT_W=64): seed all lanes with 1, `start`, `out_ready`=1 → first lane word 64'h2000_0000_0000_0401, second 1025² = 0x100801 in the low bits; `sample_cnt` = 2.
- **Reduction path:** lane 0 seed M−1 = 61'h1FFF_FFFF_FFFF_FFFE → first word 64'hDFFF_FFFF_FFFF_FBFE.
- **Seed rejection:**
  - Seed 0 on lane 2, then `start` → `seed_err` pulses 1 cycle; `busy` stays 0.
  - Seed M → same response.
- **Backpressure:** hold `out_ready`=0 for 5 cycles mid-run → `out_data` and `sample_cnt` stable; on release the stream resumes with the exact next value and no skip.
- **Stop/resume:**
  - `stop` with `out_ready`=0 → DRAIN, word held; one handshake later → IDLE.
  - Re-`start` → next value continues the sequence.
- **Reset:** `rst` mid-run → all outputs at reset values on the next cycle; `start` without reseeding is ignored.
